// File: rtl/display_scheduler_if.sv
// Bundle between requesters and the shared 4-digit display scheduler.
// Handshake: a requester raises req[i] with req_data stable and holds both until it sees the one-cycle ack[i] pulse.
interface display_scheduler_if #(
    parameter int NUM_REQ = 3
);
    logic [NUM_REQ-1:0]    req;
    logic [32*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]    ack;
    logic [15:0]           bcd_out;
    logic                  bcd_valid;
    logic [2:0]            owner;
    logic                  busy;
    logic [1:0]            dbg_state;

    modport master (
        output req, req_data,
        input  ack, bcd_out, bcd_valid, owner, busy, dbg_state
    );

    modport slave (
        input  req, req_data,
        output ack, bcd_out, bcd_valid, owner, busy, dbg_state
    );
endinterface

// File: rtl/display_scheduler.sv
// Round-robin scheduler that converts one requester's value to BCD and holds it on the display.
// Optional macro DISPLAY_SCHED_OVF_EN: values above 9999 show as 16'hFFFF instead of saturating to 9999.
module display_scheduler #(
    parameter int NUM_REQ  = 3,
    parameter int MIN_HOLD = 50_000_000
) (
    input  logic                fast_clk,
    input  logic                rst_n,
    display_scheduler_if.slave  bus
);
    localparam int HW = (MIN_HOLD > 1) ? $clog2(MIN_HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'((MIN_HOLD > 0) ? MIN_HOLD - 1 : 0);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        HOLD    = 2'd2
    } state_t;

    state_t         state, next_state;
    logic [2:0]     rr_ptr;
    logic [3:0]     bit_cnt;
    logic [HW-1:0]  hold_cnt;
    logic [29:0]    scratch;
    logic           grant_found;
    logic [2:0]     grant_idx;
    logic [31:0]    sel_data;
    logic [13:0]    sat_val;
    logic [29:0]    dd_adj, dd_next;
`ifdef DISPLAY_SCHED_OVF_EN
    logic           ovf;
`endif

    assign bus.busy      = (state != IDLE);
    assign bus.dbg_state = state;

    // First pass finds requesters at or above the pointer, second pass wraps to the bottom.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!grant_found && bus.req[i] && (3'(i) >= rr_ptr)) begin
                grant_found = 1'b1;
                grant_idx   = 3'(i);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!grant_found && bus.req[i]) begin
                grant_found = 1'b1;
                grant_idx   = 3'(i);
            end
        end
    end

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (3'(i) == grant_idx) sel_data = bus.req_data[32*i +: 32];
        end
        sat_val = (sel_data > 32'd9999) ? 14'd9999 : sel_data[13:0];
    end

    // Scratch holds BCD in [29:14] and the remaining binary in [13:0]; one adjust+shift per cycle.
    always_comb begin
        dd_adj = scratch;
        for (int d = 0; d < 4; d++) begin
            if (dd_adj[14+4*d +: 4] >= 4'd5) dd_adj[14+4*d +: 4] = dd_adj[14+4*d +: 4] + 4'd3;
        end
        dd_next = dd_adj << 1;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (grant_found) next_state = CONVERT;
            CONVERT: if (bit_cnt == 4'd13) next_state = (MIN_HOLD == 0) ? IDLE : HOLD;
            HOLD:    if (hold_cnt == HOLD_LAST) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge fast_clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_ff @(posedge fast_clk) begin
        if (!rst_n) begin
            bus.ack       <= '0;
            bus.bcd_out   <= 16'h0000;
            bus.bcd_valid <= 1'b0;
            bus.owner     <= 3'd0;
            rr_ptr        <= 3'd0;
            bit_cnt       <= 4'd0;
            hold_cnt      <= '0;
            scratch       <= '0;
`ifdef DISPLAY_SCHED_OVF_EN
            ovf           <= 1'b0;
`endif
        end else begin
            bus.ack <= '0;
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        bus.ack   <= NUM_REQ'(1) << grant_idx;
                        bus.owner <= grant_idx;
                        rr_ptr    <= (grant_idx == 3'(NUM_REQ - 1)) ? 3'd0 : grant_idx + 3'd1;
                        scratch   <= {16'd0, sat_val};
                        bit_cnt   <= 4'd0;
`ifdef DISPLAY_SCHED_OVF_EN
                        ovf       <= (sel_data > 32'd9999);
`endif
                    end
                end
                CONVERT: begin
                    scratch <= dd_next;
                    bit_cnt <= bit_cnt + 4'd1;
                    if (bit_cnt == 4'd13) begin
`ifdef DISPLAY_SCHED_OVF_EN
                        bus.bcd_out <= ovf ? 16'hFFFF : dd_next[29:14];
`else
                        bus.bcd_out <= dd_next[29:14];
`endif
                        bus.bcd_valid <= 1'b1;
                        hold_cnt      <= '0;
                    end
                end
                HOLD:    hold_cnt <= hold_cnt + HW'(1);
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_display_scheduler.sv
// Directed bench: dut_a (NUM_REQ=3, MIN_HOLD=4) for most scenarios, dut_b (MIN_HOLD=0) for back-to-back reconversion.
module tb_display_scheduler;
    logic fast_clk = 1'b0;
    logic rst_a, rst_b;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [15:0] prev_bcd;

`ifdef DISPLAY_SCHED_OVF_EN
    localparam logic [15:0] SAT_EXP = 16'hFFFF;
`else
    localparam logic [15:0] SAT_EXP = 16'h9999;
`endif

    display_scheduler_if #(.NUM_REQ(3)) bus_a ();
    display_scheduler_if #(.NUM_REQ(3)) bus_b ();

    display_scheduler #(.NUM_REQ(3), .MIN_HOLD(4)) dut_a (
        .fast_clk (fast_clk),
        .rst_n    (rst_a),
        .bus      (bus_a)
    );

    display_scheduler #(.NUM_REQ(3), .MIN_HOLD(0)) dut_b (
        .fast_clk (fast_clk),
        .rst_n    (rst_b),
        .bus      (bus_b)
    );

    // ---------------- clock / reset ----------------
    always #5 fast_clk = ~fast_clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge fast_clk);
            #1;
        end
    endtask

    task automatic reset_a();
        rst_a = 1'b0;
        tick(2);
        rst_a = 1'b1;
    endtask

    // ---------------- driver tasks ----------------
    // One transaction on dut_a starting in IDLE; returns what was observed at T+1, T+14, T+15, T+19.
    task automatic run_one(input int idx, input logic [31:0] data,
                           output logic [2:0] ack_seen, output logic [15:0] mid_bcd,
                           output logic [15:0] bcd, output logic valid,
                           output logic [2:0] own, output logic busy_end);
        bus_a.req_data[32*idx +: 32] = data;
        bus_a.req[idx] = 1'b1;
        tick(1);
        ack_seen = bus_a.ack;
        bus_a.req[idx] = 1'b0;
        tick(13);
        mid_bcd = bus_a.bcd_out;
        tick(1);
        bcd   = bus_a.bcd_out;
        valid = bus_a.bcd_valid;
        own   = bus_a.owner;
        tick(4);
        busy_end = bus_a.busy;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        n_checks++; if (bus_a.bcd_out !== 16'h0000) begin n_errors++; $display("FAIL reset_bcd got %h want 0000", bus_a.bcd_out); end
        n_checks++; if (bus_a.bcd_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid got %b want 0", bus_a.bcd_valid); end
        n_checks++; if (bus_a.ack !== 3'b000) begin n_errors++; $display("FAIL reset_ack got %b want 000", bus_a.ack); end
        n_checks++; if (bus_a.owner !== 3'd0) begin n_errors++; $display("FAIL reset_owner got %0d want 0", bus_a.owner); end
        n_checks++; if (bus_a.busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got %b want 0", bus_a.busy); end
        n_checks++; if (bus_b.busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy_b got %b want 0", bus_b.busy); end
    endtask

    task automatic test_single();
        logic [2:0] a, o; logic [15:0] m, b; logic v, be;
        run_one(0, 32'd1234, a, m, b, v, o, be);
        n_checks++; if (a !== 3'b001) begin n_errors++; $display("FAIL single_ack got %b want 001", a); end
        n_checks++; if (m !== 16'h0000) begin n_errors++; $display("FAIL single_mid_bcd got %h want 0000", m); end
        n_checks++; if (b !== 16'h1234) begin n_errors++; $display("FAIL single_bcd got %h want 1234", b); end
        n_checks++; if (v !== 1'b1) begin n_errors++; $display("FAIL single_valid got %b want 1", v); end
        n_checks++; if (o !== 3'd0) begin n_errors++; $display("FAIL single_owner got %0d want 0", o); end
        n_checks++; if (be !== 1'b0) begin n_errors++; $display("FAIL single_idle_after_hold got busy %b want 0", be); end
        prev_bcd = 16'h1234;
    endtask

    task automatic test_boundaries();
        logic [31:0] vals [6] = '{32'd0, 32'd9999, 32'd10000, 32'd70000, 32'd4095, 32'd808};
        logic [15:0] exps [6] = '{16'h0000, 16'h9999, SAT_EXP, SAT_EXP, 16'h4095, 16'h0808};
        logic [2:0] a, o; logic [15:0] m, b; logic v, be;
        for (int k = 0; k < 6; k++) begin
            int idx;
            idx = k % 3;
            run_one(idx, vals[k], a, m, b, v, o, be);
            n_checks++; if (a !== (3'b001 << idx)) begin n_errors++; $display("FAIL bound_ack[%0d] got %b want %b", k, a, 3'b001 << idx); end
            n_checks++; if (m !== prev_bcd) begin n_errors++; $display("FAIL bound_mid_bcd[%0d] got %h want %h", k, m, prev_bcd); end
            n_checks++; if (b !== exps[k]) begin n_errors++; $display("FAIL bound_bcd[%0d] data %0d got %h want %h", k, vals[k], b, exps[k]); end
            n_checks++; if (o !== 3'(idx)) begin n_errors++; $display("FAIL bound_owner[%0d] got %0d want %0d", k, o, idx); end
            prev_bcd = exps[k];
        end
    endtask

    task automatic test_round_robin();
        int          order [4] = '{0, 1, 2, 0};
        logic [15:0] exps  [4] = '{16'h0011, 16'h0022, 16'h0033, 16'h0011};
        reset_a();
        bus_a.req_data = {32'd33, 32'd22, 32'd11};
        bus_a.req = 3'b111;
        tick(1);
        for (int g = 0; g < 4; g++) begin
            if (g > 0) begin
                tick(4);
                n_checks++; if (bus_a.busy !== 1'b0) begin n_errors++; $display("FAIL rr_idle[%0d] got busy %b want 0", g, bus_a.busy); end
                tick(1);
            end
            n_checks++; if (bus_a.ack !== (3'b001 << order[g])) begin n_errors++; $display("FAIL rr_ack[%0d] got %b want %b", g, bus_a.ack, 3'b001 << order[g]); end
            n_checks++; if (bus_a.owner !== 3'(order[g])) begin n_errors++; $display("FAIL rr_owner[%0d] got %0d want %0d", g, bus_a.owner, order[g]); end
            tick(1);
            n_checks++; if (bus_a.ack !== 3'b000) begin n_errors++; $display("FAIL rr_ack_pulse[%0d] got %b want 000", g, bus_a.ack); end
            tick(13);
            n_checks++; if (bus_a.bcd_out !== exps[g]) begin n_errors++; $display("FAIL rr_bcd[%0d] got %h want %h", g, bus_a.bcd_out, exps[g]); end
        end
        bus_a.req = 3'b000;
        tick(5);
        n_checks++; if (bus_a.busy !== 1'b0) begin n_errors++; $display("FAIL rr_final_idle got busy %b want 0", bus_a.busy); end
    endtask

    task automatic test_hold_request();
        reset_a();
        bus_a.req_data[31:0] = 32'd5;
        bus_a.req[0] = 1'b1;
        tick(1);
        n_checks++; if (bus_a.ack !== 3'b001) begin n_errors++; $display("FAIL hold_first_ack got %b want 001", bus_a.ack); end
        bus_a.req[0] = 1'b0;
        tick(15);
        bus_a.req_data[63:32] = 32'd77;
        bus_a.req[1] = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick(1);
            n_checks++; if (bus_a.ack !== 3'b000) begin n_errors++; $display("FAIL hold_no_ack[%0d] got %b want 000", c, bus_a.ack); end
        end
        n_checks++; if (bus_a.busy !== 1'b0) begin n_errors++; $display("FAIL hold_idle_u got busy %b want 0", bus_a.busy); end
        n_checks++; if (bus_a.bcd_out !== 16'h0005) begin n_errors++; $display("FAIL hold_bcd5 got %h want 0005", bus_a.bcd_out); end
        tick(1);
        n_checks++; if (bus_a.ack !== 3'b010) begin n_errors++; $display("FAIL hold_ack_u1 got %b want 010", bus_a.ack); end
        bus_a.req[1] = 1'b0;
        tick(14);
        n_checks++; if (bus_a.bcd_out !== 16'h0077) begin n_errors++; $display("FAIL hold_bcd77 got %h want 0077", bus_a.bcd_out); end
        tick(4);
    endtask

    task automatic test_reset_abort();
        bus_a.req_data[31:0] = 32'd4321;
        bus_a.req[0] = 1'b1;
        tick(1);
        bus_a.req[0] = 1'b0;
        tick(4);
        n_checks++; if (bus_a.busy !== 1'b1) begin n_errors++; $display("FAIL abort_busy_before got %b want 1", bus_a.busy); end
        rst_a = 1'b0;
        tick(1);
        rst_a = 1'b1;
        n_checks++; if (bus_a.busy !== 1'b0) begin n_errors++; $display("FAIL abort_busy got %b want 0", bus_a.busy); end
        n_checks++; if (bus_a.bcd_out !== 16'h0000) begin n_errors++; $display("FAIL abort_bcd got %h want 0000", bus_a.bcd_out); end
        n_checks++; if (bus_a.bcd_valid !== 1'b0) begin n_errors++; $display("FAIL abort_valid got %b want 0", bus_a.bcd_valid); end
        for (int c = 0; c < 20; c++) begin
            n_checks++; if (bus_a.ack !== 3'b000 || bus_a.bcd_out !== 16'h0000) begin
                n_errors++; $display("FAIL abort_quiet[%0d] got ack %b bcd %h want 000 0000", c, bus_a.ack, bus_a.bcd_out);
            end
            tick(1);
        end
    endtask

    task automatic test_back_to_back();
        bus_b.req_data[95:64] = 32'd42;
        bus_b.req[2] = 1'b1;
        tick(1);
        n_checks++; if (bus_b.ack !== 3'b100) begin n_errors++; $display("FAIL b2b_ack0 got %b want 100", bus_b.ack); end
        tick(14);
        n_checks++; if (bus_b.bcd_out !== 16'h0042) begin n_errors++; $display("FAIL b2b_bcd got %h want 0042", bus_b.bcd_out); end
        n_checks++; if (bus_b.busy !== 1'b0) begin n_errors++; $display("FAIL b2b_gap0 got busy %b want 0", bus_b.busy); end
        tick(1);
        n_checks++; if (bus_b.ack !== 3'b100 || bus_b.busy !== 1'b1) begin
            n_errors++; $display("FAIL b2b_ack1 got ack %b busy %b want 100 1", bus_b.ack, bus_b.busy);
        end
        tick(14);
        n_checks++; if (bus_b.busy !== 1'b0) begin n_errors++; $display("FAIL b2b_gap1 got busy %b want 0", bus_b.busy); end
        tick(1);
        n_checks++; if (bus_b.ack !== 3'b100) begin n_errors++; $display("FAIL b2b_ack2 got %b want 100", bus_b.ack); end
        bus_b.req = 3'b000;
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        rst_a = 1'b0;
        rst_b = 1'b0;
        bus_a.req = '0;
        bus_a.req_data = '0;
        bus_b.req = '0;
        bus_b.req_data = '0;
        prev_bcd = 16'h0000;
        tick(3);
        rst_a = 1'b1;
        rst_b = 1'b1;
        test_reset();
        test_single();
        test_boundaries();
        test_round_robin();
        test_hold_request();
        test_reset_abort();
        test_back_to_back();
        tick(2);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
